riscv_cache_setup_buf: RTL

Buffered, parametrised cache address-setup stage. It sits between the core-side request port and the cache tag/data memories. A DEPTH-entry request FIFO decouples upstream from the cache pipeline stall, so upstream sees a registered `ready_o` instead of a combinational stall. The block drives the memory set index one cycle ahead of the registered request and carries invalidate/clean maintenance requests so none are lost.

---
 rtl/riscv_cache_pkg.sv | 35 +++
 rtl/riscv_cache_setup_buf_if.sv | 54 +++++
 rtl/riscv_cache_setup_fifo.sv | 64 ++++++
 rtl/riscv_cache_setup_buf.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/riscv_cache_pkg.sv
// Shared types and geometry helpers for the cache address-setup stage.
package riscv_cache_pkg;

   // Width of the address/data fields carried in a buffered request
   localparam int CACHE_XLEN = 32;

   typedef logic [2:0] biu_size_t;
   typedef logic [2:0] biu_prot_t;

   // One core-side request as it travels through the setup buffer
   typedef struct packed {
      logic [CACHE_XLEN-1:0] adr;
      biu_size_t             size;
      logic                  lock;
      biu_prot_t             prot;
      logic                  we;
      logic [CACHE_XLEN-1:0] d;
   } cache_setup_req_t;

   // Number of sets: cache_size in kbytes, block_size in bits
   function automatic int no_of_sets(input int cache_size, input int block_size, input int ways);
      return cache_size * 1024 * 8 / block_size / ways;
   endfunction

   // Byte-offset bits inside one cache block
   function automatic int no_of_block_offset_bits(input int block_size);
      return $clog2(block_size / 8);
   endfunction

   // Set-index bits
   function automatic int no_of_index_bits(input int sets);
      return $clog2(sets);
   endfunction

endpackage

// File: rtl/riscv_cache_setup_buf_if.sv
// Request/response bundle of the cache setup buffer; the _i/_o suffixes are
// seen from the buffer side.
interface riscv_cache_setup_buf_if #(
   parameter int XLEN     = 32,
   parameter int IDX_BITS = 13,
   parameter int LVL_BITS = 3
);
   import riscv_cache_pkg::*;

   logic                stall_i;
   logic                flush_i;
   logic                req_i;
   logic                ready_o;
   logic [XLEN-1:0]     adr_i;
   biu_size_t           size_i;
   logic                lock_i;
   biu_prot_t           prot_i;
   logic                we_i;
   logic [XLEN-1:0]     d_i;
   logic                invalidate_i;
   logic                clean_i;

   logic                req_o;
   logic [XLEN-1:0]     adr_o;
   biu_size_t           size_o;
   logic                lock_o;
   biu_prot_t           prot_o;
   logic                we_o;
   logic [XLEN-1:0]     q_o;
   logic                invalidate_o;
   logic                clean_o;
   logic                rreq_o;
   logic [IDX_BITS-1:0] idx_o;
   logic [LVL_BITS-1:0] level_o;
   logic                empty_o;
   logic                full_o;

   // The buffer itself
   modport slave (
      input  stall_i, flush_i, req_i, adr_i, size_i, lock_i, prot_i, we_i, d_i,
             invalidate_i, clean_i,
      output ready_o, req_o, adr_o, size_o, lock_o, prot_o, we_o, q_o,
             invalidate_o, clean_o, rreq_o, idx_o, level_o, empty_o, full_o
   );

   // The core / pipeline side driving requests into the buffer
   modport master (
      output stall_i, flush_i, req_i, adr_i, size_i, lock_i, prot_i, we_i, d_i,
             invalidate_i, clean_i,
      input  ready_o, req_o, adr_o, size_o, lock_o, prot_o, we_o, q_o,
             invalidate_o, clean_o, rreq_o, idx_o, level_o, empty_o, full_o
   );

endinterface

// File: rtl/riscv_cache_setup_fifo.sv
// DEPTH-entry request FIFO with registered level/empty/full status.
// The head entry is read combinationally; push and pop may coincide.
module riscv_cache_setup_fifo
   import riscv_cache_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int LVL_BITS = $clog2(DEPTH + 1)
)(
   input  logic                rst_ni,
   input  logic                clk_i,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  cache_setup_req_t    wdata,
   output cache_setup_req_t    rdata,
   output logic [LVL_BITS-1:0] level,
   output logic                empty,
   output logic                full
);
   localparam int PTR_BITS = $clog2(DEPTH);

   cache_setup_req_t    mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [LVL_BITS-1:0] level_nxt;

   assign rdata = mem[rd_ptr];

   // Next fill level; a simultaneous push and pop leaves it unchanged
   always_comb begin
      level_nxt = level;
      if (flush)              level_nxt = '0;
      else if (push && !pop)  level_nxt = level + 1'b1;
      else if (pop && !push)  level_nxt = level - 1'b1;
   end

   // Storage write; entries need no reset because level guards them
   always_ff @(posedge clk_i) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally at DEPTH; status flags are registered
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
         level <= level_nxt;
         empty <= (level_nxt == '0);
         full  <= (level_nxt == LVL_BITS'(DEPTH));
      end
   end

endmodule

// File: rtl/riscv_cache_setup_buf.sv
// Buffered cache address-setup stage: request FIFO, output stage with
// bypass, look-ahead set index and sticky maintenance flags.
module riscv_cache_setup_buf
   import riscv_cache_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SIZE       = 64,
   parameter int BLOCK_SIZE = XLEN,
   parameter int WAYS       = 2,
   parameter int DEPTH      = 4
)(
   input logic                    rst_ni,
   input logic                    clk_i,
   riscv_cache_setup_buf_if.slave bus
);
   localparam int SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS);
   localparam int BLK_OFFS_BITS = no_of_block_offset_bits(BLOCK_SIZE);
   localparam int IDX_BITS      = no_of_index_bits(SETS);
   localparam int LVL_BITS      = $clog2(DEPTH + 1);

   cache_setup_req_t    in_req;
   cache_setup_req_t    head_req;
   cache_setup_req_t    next_req;
   cache_setup_req_t    out_q;
   logic                push;
   logic                advance;
   logic                fifo_push;
   logic                fifo_pop;
   logic                next_valid;
   logic                out_valid;
   logic                pend_inv;
   logic                pend_cln;
   logic                inv_q;
   logic                cln_q;
   logic                flush_q;
   logic [IDX_BITS-1:0] idx_q;
   logic [IDX_BITS-1:0] next_idx;
   logic [LVL_BITS-1:0] level;
   logic                empty;
   logic                full;

   // Pack the incoming request attributes into one record
   always_comb begin
      in_req      = '0;
      in_req.adr  = CACHE_XLEN'(bus.adr_i);
      in_req.size = bus.size_i;
      in_req.lock = bus.lock_i;
      in_req.prot = bus.prot_i;
      in_req.we   = bus.we_i;
      in_req.d    = CACHE_XLEN'(bus.d_i);
   end

   assign push    = bus.req_i & ~full & ~bus.flush_i;
   assign advance = ~bus.stall_i;

   // Output-stage candidate: FIFO head first, else a bypassed input
   always_comb begin
      next_req   = in_req;
      next_valid = 1'b0;
      if (!empty) begin
         next_req   = head_req;
         next_valid = 1'b1;
      end else if (push) begin
         next_valid = 1'b1;
      end
   end

   // A request that goes straight to the output stage never enters the FIFO
   assign fifo_push = push & ~(advance & empty);
   assign fifo_pop  = advance & ~empty & ~bus.flush_i;
   assign next_idx  = next_req.adr[BLK_OFFS_BITS +: IDX_BITS];

   riscv_cache_setup_fifo #(
      .DEPTH    (DEPTH),
      .LVL_BITS (LVL_BITS)
   ) u_fifo (
      .rst_ni (rst_ni),
      .clk_i  (clk_i),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .flush  (bus.flush_i),
      .wdata  (in_req),
      .rdata  (head_req),
      .level  (level),
      .empty  (empty),
      .full   (full)
   );

   // Output stage: flush wins, then advance loads the candidate
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid <= 1'b0;
         out_q     <= '0;
      end else if (bus.flush_i) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= next_valid;
         if (next_valid) out_q <= next_req;
      end
   end

   // Sticky maintenance requests, handed to the output stage on an advance
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_inv <= 1'b0;
         pend_cln <= 1'b0;
         inv_q    <= 1'b0;
         cln_q    <= 1'b0;
      end else if (advance && !bus.flush_i) begin
         inv_q    <= bus.invalidate_i | pend_inv;
         cln_q    <= bus.clean_i | pend_cln;
         pend_inv <= 1'b0;
         pend_cln <= 1'b0;
      end else begin
         pend_inv <= pend_inv | bus.invalidate_i;
         pend_cln <= pend_cln | bus.clean_i;
      end
   end

   // Held set index used while stalled; refreshed on advance or after a flush
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flush_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         flush_q <= bus.flush_i;
         if ((advance && !bus.flush_i && next_valid) || flush_q) idx_q <= next_idx;
      end
   end

   assign bus.ready_o      = ~full;
   assign bus.req_o        = out_valid;
   assign bus.adr_o        = XLEN'(out_q.adr);
   assign bus.size_o       = out_q.size;
   assign bus.lock_o       = out_q.lock;
   assign bus.prot_o       = out_q.prot;
   assign bus.we_o         = out_q.we;
   assign bus.q_o          = XLEN'(out_q.d);
   assign bus.invalidate_o = inv_q;
   assign bus.clean_o      = cln_q;
   assign bus.rreq_o       = advance & next_valid & ~next_req.we;
   assign bus.idx_o        = bus.stall_i ? idx_q : next_idx;
   assign bus.level_o      = level;
   assign bus.empty_o      = empty;
   assign bus.full_o       = full;

endmodule
